// File: rtl/write_port_arbiter.sv
// Two-requester register-bank write port: round-robin arbitration on a single
// last-grant bit, one registered write per cycle, read-forward match flags.
module write_port_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ReqA,
  input  logic [AW-1:0] DirA,
  input  logic [DW-1:0] DiA,
  output logic          GntA,
  input  logic          ReqB,
  input  logic [AW-1:0] DirB,
  input  logic [DW-1:0] DiB,
  output logic          GntB,
  output logic [AW-1:0] Dir,
  output logic [DW-1:0] Di,
  output logic          RegWrite,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic          Fwd1,
  output logic          Fwd2,
  output logic [CW-1:0] WrCount
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic          last_q;
  logic [AW-1:0] dir_q, dir_d;
  logic [DW-1:0] di_q, di_d;
  logic          wen_q, wen_d;
  logic [CW-1:0] cnt_q;
  logic          gnt_a, gnt_b, accept;

  // Last=1 means B was granted last, so A wins the next tie.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (ReqA && ReqB) begin
        gnt_a = last_q;
        gnt_b = !last_q;
      end else begin
        gnt_a = ReqA;
        gnt_b = ReqB;
      end
    end
  end

  assign accept = gnt_a || gnt_b;

  always_comb begin
    dir_d = dir_q;
    di_d  = di_q;
    wen_d = 1'b0;
    if (accept) begin
      dir_d = gnt_b ? DirB : DirA;
      di_d  = gnt_b ? DiB  : DiA;
      wen_d = (dir_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      dir_q  <= '0;
      di_q   <= '0;
      wen_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dir_q <= dir_d;
      di_q  <= di_d;
      wen_q <= wen_d;
      if (accept) last_q <= gnt_b;
      if (wen_d) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign GntA     = gnt_a;
  assign GntB     = gnt_b;
  assign Dir      = dir_q;
  assign Di       = di_q;
  assign RegWrite = wen_q;
  assign WrCount  = cnt_q;
  assign Fwd1     = wen_q && (dir_q == RA1);
  assign Fwd2     = wen_q && (dir_q == RA2);

endmodule

// File: tb/tb_write_port_arbiter.sv
// Directed bench for write_port_arbiter, built with a 4-bit write counter so
// saturation is reachable in a few cycles.
module tb_write_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ReqA, ReqB;
  logic [AW-1:0] DirA, DirB, RA1, RA2;
  logic [DW-1:0] DiA, DiB;
  logic          GntA, GntB, RegWrite, Fwd1, Fwd2;
  logic [AW-1:0] Dir;
  logic [DW-1:0] Di;
  logic [CW-1:0] WrCount;

  int checks = 0;
  int errors = 0;

  write_port_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .ReqA(ReqA), .DirA(DirA), .DiA(DiA), .GntA(GntA),
    .ReqB(ReqB), .DirB(DirB), .DiB(DiB), .GntB(GntB),
    .Dir(Dir), .Di(Di), .RegWrite(RegWrite),
    .RA1(RA1), .RA2(RA2), .Fwd1(Fwd1), .Fwd2(Fwd2),
    .WrCount(WrCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ReqA = 1'b1; ReqB = 1'b1;
    DirA = 5'd1; DirB = 5'd2; DiA = 32'h5; DiB = 32'h6;
    RA1 = 5'd0; RA2 = 5'd0;
    #1;
    chk("rst_gnta", 32'(GntA), 32'd0);
    chk("rst_gntb", 32'(GntB), 32'd0);
    tick();
    tick();
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_dir", 32'(Dir), 32'd0);
    chk("rst_di", Di, 32'd0);
    chk("rst_wrcount", 32'(WrCount), 32'd0);

    // single write from A
    rst = 1'b0; ReqB = 1'b0;
    DirA = 5'd3; DiA = 32'h11;
    #1;
    chk("a_only_gnta", 32'(GntA), 32'd1);
    chk("a_only_gntb", 32'(GntB), 32'd0);
    tick();
    ReqA = 1'b0;
    chk("a_only_dir", 32'(Dir), 32'd3);
    chk("a_only_di", Di, 32'h11);
    chk("a_only_regwrite", 32'(RegWrite), 32'd1);
    chk("a_only_wrcount", 32'(WrCount), 32'd1);
    tick();
    chk("idle_regwrite", 32'(RegWrite), 32'd0);
    chk("idle_dir_hold", 32'(Dir), 32'd3);
    chk("idle_di_hold", Di, 32'h11);

    // fresh reset, then continuous dual requests alternate A,B,A,B
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ReqA = 1'b1; DirA = 5'd1; DiA = 32'hA1;
    ReqB = 1'b1; DirB = 5'd2; DiB = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_gnta", 32'(GntA), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_gntb", 32'(GntB), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("alt_regwrite", 32'(RegWrite), 32'd1);
      chk("alt_dir", 32'(Dir), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    ReqA = 1'b0; ReqB = 1'b0;
    chk("alt_wrcount", 32'(WrCount), 32'd4);

    // write to address 0: accepted, no RegWrite, counter unchanged
    ReqB = 1'b1; DirB = 5'd0; DiB = 32'hFF;
    #1;
    chk("zero_gntb", 32'(GntB), 32'd1);
    tick();
    ReqB = 1'b0;
    chk("zero_regwrite", 32'(RegWrite), 32'd0);
    chk("zero_wrcount", 32'(WrCount), 32'd4);
    chk("zero_di", Di, 32'hFF);

    // following tie goes to A; then forwarding flags
    ReqA = 1'b1; DirA = 5'd7; DiA = 32'h77;
    ReqB = 1'b1; DirB = 5'd8; DiB = 32'h88;
    #1;
    chk("tie_after_b_gnta", 32'(GntA), 32'd1);
    chk("tie_after_b_gntb", 32'(GntB), 32'd0);
    tick();
    ReqA = 1'b0; ReqB = 1'b0;
    RA1 = 5'd7; RA2 = 5'd8;
    #1;
    chk("fwd_dir", 32'(Dir), 32'd7);
    chk("fwd1_hit", 32'(Fwd1), 32'd1);
    chk("fwd2_miss", 32'(Fwd2), 32'd0);
    chk("fwd_wrcount", 32'(WrCount), 32'd5);
    tick();
    chk("fwd_idle_regwrite", 32'(RegWrite), 32'd0);
    chk("fwd1_idle", 32'(Fwd1), 32'd0);
    chk("fwd2_idle", 32'(Fwd2), 32'd0);

    // same address from both: last grant was A, so B then A; A's data remains
    ReqA = 1'b1; DirA = 5'd9; DiA = 32'h1;
    ReqB = 1'b1; DirB = 5'd9; DiB = 32'h2;
    #1;
    chk("same_first_gntb", 32'(GntB), 32'd1);
    tick();
    ReqB = 1'b0;
    chk("same_first_di", Di, 32'h2);
    #1;
    chk("same_second_gnta", 32'(GntA), 32'd1);
    tick();
    ReqA = 1'b0;
    chk("same_final_dir", 32'(Dir), 32'd9);
    chk("same_final_di", Di, 32'h1);
    chk("same_wrcount", 32'(WrCount), 32'd7);

    // reset in the middle of continuous dual requests
    ReqA = 1'b1; DirA = 5'd4; DiA = 32'h44;
    ReqB = 1'b1; DirB = 5'd6; DiB = 32'h66;
    tick();
    chk("pre_rst_wrcount", 32'(WrCount), 32'd8);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnta", 32'(GntA), 32'd0);
    chk("mid_rst_gntb", 32'(GntB), 32'd0);
    tick();
    chk("mid_rst_regwrite", 32'(RegWrite), 32'd0);
    chk("mid_rst_wrcount", 32'(WrCount), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_gnta", 32'(GntA), 32'd1);
    chk("post_rst_gntb", 32'(GntB), 32'd0);
    tick();
    ReqB = 1'b0;
    chk("post_rst_dir", 32'(Dir), 32'd4);
    chk("post_rst_wrcount", 32'(WrCount), 32'd1);

    // counter saturation
    repeat (14) tick();
    chk("sat_reach", 32'(WrCount), 32'd15);
    repeat (3) tick();
    chk("sat_hold", 32'(WrCount), 32'd15);
    chk("sat_regwrite", 32'(RegWrite), 32'd1);
    ReqA = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/write_port_arbiter.md
WRITE_PORT_ARBITER -- requirements
Module: write_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data width of the register-bank write port.
REQ-002 SHALL have parameter AW, default 5, register address width (32 entries).
REQ-003 SHALL have parameter CW, default 16, width of the accepted-write counter.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ReqA  input  1  requester A (ALU writeback) write request.
REQ-007 SHALL have port DirA  input  AW  requester A destination register.
REQ-008 SHALL have port DiA  input  DW  requester A write data.
REQ-009 SHALL have port GntA  output  1  requester A grant; write accepted on the edge where ReqA&&GntA.
REQ-010 SHALL have ports ReqB, DirB, DiB, GntB with the same directions, widths and meanings as the A ports, for requester B (load unit).
REQ-011 SHALL have port Dir  output  AW  registered write address to the register bank.
REQ-012 SHALL have port Di  output  DW  registered write data to the register bank.
REQ-013 SHALL have port RegWrite  output  1  registered write enable to the register bank.
REQ-014 SHALL have ports RA1, RA2  input  AW  register-bank read addresses currently being issued.
REQ-015 SHALL have ports Fwd1, Fwd2  output  1  RA1/RA2 matches the write currently driven on Dir/Di.
REQ-016 SHALL have port WrCount  output  CW  number of writes driven with RegWrite=1 since reset.

Function
REQ-017 SHALL hold a one-bit last-grant pointer Last (0=A, 1=B) as its only arbitration state.
REQ-018 SHALL grant combinationally: only ReqA -> GntA=1; only ReqB -> GntB=1; both -> grant the requester not equal to Last; neither -> no grant.
REQ-019 SHALL never assert GntA and GntB in the same cycle, and SHALL never assert a grant without the matching request.
REQ-020 SHALL update Last to the granted requester on every edge with an accepted write; unchanged otherwise.
REQ-021 SHALL, on an edge with an accepted write, load Dir/Di with the granted requester's address/data and set RegWrite=1 unless that address is 0.
REQ-022 SHALL treat a write to address 0 as accepted (grant given, Last updated) but drive RegWrite=0 for it.
REQ-023 SHALL drive RegWrite=0 on the cycle after any edge with no accepted write; Dir/Di hold their previous values.
REQ-024 SHALL give a fixed latency of exactly one cycle from accepted request to RegWrite pulse; each RegWrite pulse lasts exactly one cycle.
REQ-025 SHALL sustain one accepted write per cycle; under continuous requests from both, grants alternate A,B,A,B...
REQ-026 SHALL bound waiting: a requester holding its request is granted within 2 cycles.
REQ-027 SHALL process both requesters targeting the same address in arbitration order; the later grant's data ends in the bank.
REQ-028 SHALL drive Fwd1 = RegWrite && (Dir==RA1), Fwd2 = RegWrite && (Dir==RA2), combinationally from registered outputs.
REQ-029 SHALL increment WrCount on each edge that loads RegWrite=1, saturating at all-ones (no wrap).
REQ-030 SHALL require requesters to hold Req/Dir/Di stable until granted; it SHALL not latch ungranted requests.

Reset
REQ-031 SHALL, on an edge with rst=1, set Dir=0, Di=0, RegWrite=0, WrCount=0, Last=1 (A wins first tie).
REQ-032 SHALL force GntA=GntB=0 while rst=1; a request present during reset is not accepted.
REQ-033 SHALL, on reset asserted mid-stream, drop any pending output so RegWrite=0 the cycle after the reset edge.

Verification
REQ-034 Reset, then ReqA=1,DirA=3,DiA=0x11 alone -> GntA=1 that cycle; next cycle Dir=3,Di=0x11,RegWrite=1; WrCount=1.
REQ-035 ReqA and ReqB both held 4 cycles after reset -> grants A,B,A,B; RegWrite=1 for 4 consecutive cycles; WrCount=4.
REQ-036 ReqB=1,DirB=0,DiB=0xFF -> GntB=1; next cycle RegWrite=0, WrCount unchanged; next tie goes to A.
REQ-037 Write to Dir=7 driven with RA1=7,RA2=8 -> Fwd1=1,Fwd2=0; same cycle with RegWrite=0 -> Fwd1=Fwd2=0.
REQ-038 rst=1 during continuous dual requests -> GntA=GntB=0 during reset, RegWrite=0 next cycle, WrCount=0; after release A granted first.
REQ-039 Force WrCount to all-ones region (2^CW writes, or CW=4 build) -> counter stays at all-ones on further writes.
